// File: rtl/nap_vertical_stream_mux.sv
// N-channel packet mux/demux between user streams and one vertical NAP data-stream port pair.
// Tx: packet-atomic arbitration into a 2-entry skid buffer. Rx: source-address routing via a shared FIFO.
module nap_vertical_stream_mux #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned DATA_WIDTH    = 293,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_ADDR = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int unsigned ARB_MODE      = 0,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_CH-1:0]            i_ch_tx_valid,
  input  logic [NUM_CH-1:0]            i_ch_tx_sop,
  input  logic [NUM_CH-1:0]            i_ch_tx_eop,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_tx_data,
  output logic [NUM_CH-1:0]            o_ch_tx_ready,
  output logic                         o_nap_tx_valid,
  output logic                         o_nap_tx_sop,
  output logic                         o_nap_tx_eop,
  output logic [ADDR_WIDTH-1:0]        o_nap_tx_dest,
  output logic [DATA_WIDTH-1:0]        o_nap_tx_data,
  input  logic                         i_nap_tx_ready,
  input  logic                         i_nap_rx_valid,
  input  logic                         i_nap_rx_sop,
  input  logic                         i_nap_rx_eop,
  input  logic [ADDR_WIDTH-1:0]        i_nap_rx_src,
  input  logic [DATA_WIDTH-1:0]        i_nap_rx_data,
  output logic                         o_nap_rx_ready,
  output logic [NUM_CH-1:0]            o_ch_rx_valid,
  output logic                         o_ch_rx_sop,
  output logic                         o_ch_rx_eop,
  output logic [DATA_WIDTH-1:0]        o_ch_rx_data,
  input  logic [NUM_CH-1:0]            i_ch_rx_ready,
  output logic [15:0]                  o_rx_drop_count
);

  localparam int unsigned CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PW  = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned TXW = ADDR_WIDTH + 2 + DATA_WIDTH;
  localparam int unsigned RXW = CW + 2 + DATA_WIDTH;

  typedef enum logic {StIdle, StLocked} tx_state_e;

  // Held low for the first cycle after reset so no ready is raised while reset is applied.
  logic r_run;

  // ---------------- Tx ----------------
  tx_state_e       r_tx_state, w_tx_state;
  logic [CW-1:0]   r_lock, w_lock, r_ptr, w_ptr, w_win, w_sel, w_start, w_jc;
  int unsigned     w_jv;
  logic            w_found, w_tx_acc, w_sk_pop, w_sk_full;
  logic [NUM_CH-1:0] w_tx_ready;
  logic [TXW-1:0]  r_sk0, r_sk1, w_sk0, w_sk1, w_tx_in;
  logic [1:0]      r_sk_cnt, w_sk_cnt;
  logic [ADDR_WIDTH-1:0] w_tx_dest;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic            w_tx_sop, w_tx_eop;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_jv    = 0;
    w_jc    = '0;
    w_start = (ARB_MODE == 1) ? '0 : r_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      w_jv = (32'(w_start) + k) % NUM_CH;
      w_jc = CW'(w_jv);
      if (!w_found && i_ch_tx_valid[w_jc]) begin
        w_found = 1'b1;
        w_win   = w_jc;
      end
    end
  end

  assign w_sel     = (r_tx_state == StLocked) ? r_lock : w_win;
  assign w_sk_full = (r_sk_cnt == 2'd2);
  assign w_sk_pop  = (r_sk_cnt != 2'd0) && i_nap_tx_ready;

  always_comb begin
    w_tx_dest = '0;
    w_tx_data = '0;
    w_tx_sop  = 1'b0;
    w_tx_eop  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel == CW'(k)) begin
        w_tx_dest = CH_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_tx_data = i_ch_tx_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_tx_sop  = i_ch_tx_sop[k];
        w_tx_eop  = i_ch_tx_eop[k];
      end
    end
  end

  always_comb begin
    w_tx_ready = '0;
    if (r_run && !w_sk_full) begin
      if (r_tx_state == StLocked) w_tx_ready[r_lock] = 1'b1;
      else if (w_found)           w_tx_ready[w_win]  = 1'b1;
    end
  end

  assign o_ch_tx_ready = w_tx_ready;
  assign w_tx_acc      = |(i_ch_tx_valid & w_tx_ready);
  // A beat taken while idle always opens a packet, even if the user forgot sop.
  assign w_tx_in = {w_tx_dest, (r_tx_state == StIdle) | w_tx_sop, w_tx_eop, w_tx_data};

  always_comb begin
    w_tx_state = r_tx_state;
    w_lock     = r_lock;
    w_ptr      = r_ptr;
    if (w_tx_acc) begin
      if (w_tx_eop) begin
        w_tx_state = StIdle;
        w_ptr      = (32'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CW'(1);
      end else begin
        w_tx_state = StLocked;
        w_lock     = w_sel;
      end
    end
  end

  always_comb begin
    w_sk0    = r_sk0;
    w_sk1    = r_sk1;
    w_sk_cnt = r_sk_cnt;
    if (w_sk_pop) begin
      w_sk0    = r_sk1;
      w_sk_cnt = r_sk_cnt - 2'd1;
    end
    if (w_tx_acc) begin
      if (w_sk_cnt == 2'd0) w_sk0 = w_tx_in;
      else                  w_sk1 = w_tx_in;
      w_sk_cnt = w_sk_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_run      <= 1'b0;
      r_tx_state <= StIdle;
      r_lock     <= '0;
      r_ptr      <= '0;
      r_sk0      <= '0;
      r_sk1      <= '0;
      r_sk_cnt   <= '0;
    end else begin
      r_run      <= 1'b1;
      r_tx_state <= w_tx_state;
      r_lock     <= w_lock;
      r_ptr      <= w_ptr;
      r_sk0      <= w_sk0;
      r_sk1      <= w_sk1;
      r_sk_cnt   <= w_sk_cnt;
    end
  end

  assign o_nap_tx_valid = (r_sk_cnt != 2'd0);
  assign o_nap_tx_dest  = r_sk0[TXW-1 -: ADDR_WIDTH];
  assign o_nap_tx_sop   = o_nap_tx_valid & r_sk0[DATA_WIDTH+1];
  assign o_nap_tx_eop   = o_nap_tx_valid & r_sk0[DATA_WIDTH];
  assign o_nap_tx_data  = r_sk0[DATA_WIDTH-1:0];

  // ---------------- Rx ----------------
  logic            r_rx_in_pkt, r_rx_drop;
  logic [CW-1:0]   r_rx_tag, w_rx_tag, w_match_idx, w_head_tag;
  logic            w_match, w_rx_start, w_rx_drop, w_rx_ready, w_rx_acc, w_rx_push, w_rx_pop;
  logic            w_empty, w_full;
  logic [PW:0]     r_wp, r_rp;
  logic [RXW-1:0]  r_mem [RX_FIFO_DEPTH];
  logic [RXW-1:0]  w_head;
  logic [NUM_CH-1:0] w_rx_vld;
  logic [15:0]     r_drop_cnt;

  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (CH_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] == i_nap_rx_src) begin
        w_match     = 1'b1;
        w_match_idx = CW'(k);
      end
    end
  end

  assign w_rx_start = !r_rx_in_pkt || i_nap_rx_sop;
  assign w_rx_drop  = w_rx_start ? !w_match : r_rx_drop;
  assign w_rx_tag   = w_rx_start ? w_match_idx : r_rx_tag;

  assign w_empty    = (r_wp == r_rp);
  assign w_full     = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_head     = r_mem[r_rp[PW-1:0]];
  assign w_head_tag = w_head[RXW-1 -: CW];
  assign w_rx_pop   = !w_empty && i_ch_rx_ready[w_head_tag];
  assign w_rx_ready = r_run && (w_rx_drop || !w_full || w_rx_pop);
  assign w_rx_acc   = i_nap_rx_valid && w_rx_ready;
  assign w_rx_push  = w_rx_acc && !w_rx_drop;

  always_comb begin
    w_rx_vld = '0;
    if (!w_empty) w_rx_vld[w_head_tag] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rx_in_pkt <= 1'b0;
      r_rx_drop   <= 1'b0;
      r_rx_tag    <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_rx_acc) begin
        r_rx_in_pkt <= !i_nap_rx_eop;
        r_rx_drop   <= w_rx_drop;
        r_rx_tag    <= w_rx_tag;
        if (w_rx_start && w_rx_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_rx_push) r_wp <= r_wp + 1'b1;
      if (w_rx_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rx_push) r_mem[r_wp[PW-1:0]] <= {w_rx_tag, i_nap_rx_sop, i_nap_rx_eop, i_nap_rx_data};
  end

  assign o_nap_rx_ready  = w_rx_ready;
  assign o_ch_rx_valid   = w_rx_vld;
  assign o_ch_rx_sop     = !w_empty && w_head[DATA_WIDTH+1];
  assign o_ch_rx_eop     = !w_empty && w_head[DATA_WIDTH];
  assign o_ch_rx_data    = w_head[DATA_WIDTH-1:0];
  assign o_rx_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_nap_vertical_stream_mux.sv
// Directed bench: one round-robin and one fixed-priority instance share all inputs.
module tb_nap_vertical_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  tx_valid, tx_sop, tx_eop;
  logic [63:0] tx_data;
  logic        nap_tx_ready;
  logic        rx_valid, rx_sop, rx_eop;
  logic [3:0]  rx_src;
  logic [15:0] rx_data;
  logic [3:0]  ch_rx_ready;

  logic [3:0]  rr_ch_tx_ready, fp_ch_tx_ready, rr_ch_rx_valid, fp_ch_rx_valid;
  logic        rr_tx_valid, rr_tx_sop, rr_tx_eop, fp_tx_valid, fp_tx_sop, fp_tx_eop;
  logic [3:0]  rr_tx_dest, fp_tx_dest;
  logic [15:0] rr_tx_data, fp_tx_data, rr_rx_data, fp_rx_data;
  logic        rr_rx_ready, fp_rx_ready, rr_rx_sop, rr_rx_eop, fp_rx_sop, fp_rx_eop;
  logic [15:0] rr_drop, fp_drop;

  nap_vertical_stream_mux #(
    .NUM_CH(4), .DATA_WIDTH(16), .ADDR_WIDTH(4), .CH_ADDR(16'h3210), .ARB_MODE(0),
    .RX_FIFO_DEPTH(4)
  ) u_rr (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ch_tx_valid(tx_valid), .i_ch_tx_sop(tx_sop), .i_ch_tx_eop(tx_eop),
    .i_ch_tx_data(tx_data), .o_ch_tx_ready(rr_ch_tx_ready),
    .o_nap_tx_valid(rr_tx_valid), .o_nap_tx_sop(rr_tx_sop), .o_nap_tx_eop(rr_tx_eop),
    .o_nap_tx_dest(rr_tx_dest), .o_nap_tx_data(rr_tx_data), .i_nap_tx_ready(nap_tx_ready),
    .i_nap_rx_valid(rx_valid), .i_nap_rx_sop(rx_sop), .i_nap_rx_eop(rx_eop),
    .i_nap_rx_src(rx_src), .i_nap_rx_data(rx_data), .o_nap_rx_ready(rr_rx_ready),
    .o_ch_rx_valid(rr_ch_rx_valid), .o_ch_rx_sop(rr_rx_sop), .o_ch_rx_eop(rr_rx_eop),
    .o_ch_rx_data(rr_rx_data), .i_ch_rx_ready(ch_rx_ready), .o_rx_drop_count(rr_drop)
  );

  nap_vertical_stream_mux #(
    .NUM_CH(4), .DATA_WIDTH(16), .ADDR_WIDTH(4), .CH_ADDR(16'h3210), .ARB_MODE(1),
    .RX_FIFO_DEPTH(4)
  ) u_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ch_tx_valid(tx_valid), .i_ch_tx_sop(tx_sop), .i_ch_tx_eop(tx_eop),
    .i_ch_tx_data(tx_data), .o_ch_tx_ready(fp_ch_tx_ready),
    .o_nap_tx_valid(fp_tx_valid), .o_nap_tx_sop(fp_tx_sop), .o_nap_tx_eop(fp_tx_eop),
    .o_nap_tx_dest(fp_tx_dest), .o_nap_tx_data(fp_tx_data), .i_nap_tx_ready(nap_tx_ready),
    .i_nap_rx_valid(rx_valid), .i_nap_rx_sop(rx_sop), .i_nap_rx_eop(rx_eop),
    .i_nap_rx_src(rx_src), .i_nap_rx_data(rx_data), .o_nap_rx_ready(fp_rx_ready),
    .o_ch_rx_valid(fp_ch_rx_valid), .o_ch_rx_sop(fp_rx_sop), .o_ch_rx_eop(fp_rx_eop),
    .o_ch_rx_data(fp_rx_data), .i_ch_rx_ready(ch_rx_ready), .o_rx_drop_count(fp_drop)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Tx stimulus state per channel and expected beat list {dest, sop, eop, data}.
  int          len [4];
  int          npkt[4];
  int          beat[4];
  int          pkt [4];
  bit          sop_off;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] dat(input int c, input int p, input int b);
    return 16'(c * 256 + p * 16 + b);
  endfunction

  task automatic drive_tx();
    for (int c = 0; c < 4; c++) begin
      tx_valid[c]          = (pkt[c] < npkt[c]);
      tx_sop[c]            = (beat[c] == 0) && !sop_off;
      tx_eop[c]            = (beat[c] == len[c] - 1);
      tx_data[c*16 +: 16]  = dat(c, pkt[c], beat[c]);
    end
  endtask

  task automatic clear_tx();
    for (int c = 0; c < 4; c++) begin
      len[c] = 1; npkt[c] = 0; beat[c] = 0; pkt[c] = 0;
    end
    sop_off = 1'b0;
    exp_q.delete();
    drive_tx();
  endtask

  task automatic exp_pkt(input int c, input int p, input int l);
    for (int b = 0; b < l; b++)
      exp_q.push_back({10'b0, 4'(c), b == 0, b == l - 1, dat(c, p, b)});
  endtask

  task automatic run_tx(input int ncyc, input bit use_fp, input bit tog, input bit gap_chk);
    int got;
    logic [3:0]  rdy, acc;
    logic        ov;
    logic [21:0] ob;
    got = 0;
    drive_tx();
    repeat (ncyc) begin
      @(negedge clk);
      rdy = use_fp ? fp_ch_tx_ready : rr_ch_tx_ready;
      ov  = use_fp ? fp_tx_valid : rr_tx_valid;
      ob  = use_fp ? {fp_tx_dest, fp_tx_sop, fp_tx_eop, fp_tx_data}
                   : {rr_tx_dest, rr_tx_sop, rr_tx_eop, rr_tx_data};
      check_eq("tx_ready_onehot0", 32'($countones(rdy) <= 1), 32'd1);
      if (gap_chk && got > 0 && got < exp_q.size()) check_eq("tx_no_gap", {31'b0, ov}, 32'd1);
      if (ov && nap_tx_ready) begin
        if (got < exp_q.size()) check_eq($sformatf("tx_beat%0d", got), {10'b0, ob}, exp_q[got]);
        got++;
      end
      acc = tx_valid & rdy;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) begin
          if (beat[c] == len[c] - 1) begin
            beat[c] = 0;
            pkt[c]++;
          end else begin
            beat[c]++;
          end
        end
      end
      if (tog) nap_tx_ready = ~nap_tx_ready;
      drive_tx();
    end
    check_eq("tx_count", 32'(got), 32'(exp_q.size()));
  endtask

  // Rx stimulus {src, sop, eop, data} and expected {onehot, sop, eop, data}.
  logic [21:0] rx_beats[$];
  logic [21:0] rx_exp[$];

  task automatic drive_rx(input int idx);
    if (idx < rx_beats.size()) begin
      rx_valid = 1'b1;
      {rx_src, rx_sop, rx_eop, rx_data} = rx_beats[idx];
    end else begin
      rx_valid = 1'b0;
      {rx_src, rx_sop, rx_eop, rx_data} = '0;
    end
  endtask

  task automatic run_rx(input int ncyc);
    int   idx, got;
    logic acc;
    idx = 0;
    got = 0;
    drive_rx(0);
    repeat (ncyc) begin
      @(negedge clk);
      check_eq("rx_valid_onehot0", 32'($countones(rr_ch_rx_valid) <= 1), 32'd1);
      if (|(rr_ch_rx_valid & ch_rx_ready)) begin
        if (got < rx_exp.size())
          check_eq($sformatf("rx_beat%0d", got),
                   {10'b0, rr_ch_rx_valid, rr_rx_sop, rr_rx_eop, rr_rx_data}, {10'b0, rx_exp[got]});
        got++;
      end
      acc = rx_valid && rr_rx_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      drive_rx(idx);
    end
    check_eq("rx_count", 32'(got), 32'(rx_exp.size()));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   idx, nacc, first_acc, first_vld;
    logic acc;

    // Reset with every input active.
    rst_n        = 1'b0;
    tx_valid     = 4'hF; tx_sop = 4'hF; tx_eop = 4'hF; tx_data = 64'h1234_5678_9ABC_DEF0;
    nap_tx_ready = 1'b1;
    rx_valid     = 1'b1; rx_sop = 1'b1; rx_eop = 1'b1; rx_src = 4'h9; rx_data = 16'hFFFF;
    ch_rx_ready  = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ch_tx_ready", 32'(rr_ch_tx_ready), 32'd0);
    check_eq("rst_nap_tx_valid", {31'b0, rr_tx_valid}, 32'd0);
    check_eq("rst_nap_tx_sop_eop_dest", {26'b0, rr_tx_sop, rr_tx_eop, rr_tx_dest}, 32'd0);
    check_eq("rst_nap_rx_ready", {31'b0, rr_rx_ready}, 32'd0);
    check_eq("rst_ch_rx_valid", 32'(rr_ch_rx_valid), 32'd0);
    check_eq("rst_drop_count", 32'(rr_drop), 32'd0);

    // First post-reset packet on ch2 without sop: dest 2, sop forced.
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    clear_tx();
    len[2] = 1; npkt[2] = 1; sop_off = 1'b1;
    exp_pkt(2, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_tx(6, 1'b0, 1'b0, 1'b0);

    // Round-robin, all channels offering two 2-beat packets.
    clear_tx();
    do_reset(2);
    for (int c = 0; c < 4; c++) begin
      len[c] = 2; npkt[c] = 2;
    end
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++) exp_pkt(c, p, 2);
    run_tx(24, 1'b0, 1'b0, 1'b1);

    // Fixed priority: ch1 two 3-beat packets beat ch3.
    clear_tx();
    do_reset(2);
    len[1] = 3; npkt[1] = 2;
    len[3] = 2; npkt[3] = 1;
    exp_pkt(1, 0, 3);
    exp_pkt(1, 1, 3);
    exp_pkt(3, 0, 2);
    run_tx(16, 1'b1, 1'b0, 1'b1);

    // Back-pressure toggling during a 5-beat ch0 packet.
    clear_tx();
    do_reset(2);
    len[0] = 5; npkt[0] = 1;
    exp_pkt(0, 0, 5);
    nap_tx_ready = 1'b1;
    run_tx(24, 1'b0, 1'b1, 1'b0);
    nap_tx_ready = 1'b1;
    clear_tx();

    // Rx routing; non-sop src values must be ignored.
    ch_rx_ready = 4'hF;
    rx_beats.delete();
    rx_exp.delete();
    drive_rx(0);
    do_reset(2);
    rx_beats.push_back({4'h1, 1'b1, 1'b0, 16'hB000});
    rx_beats.push_back({4'h3, 1'b0, 1'b0, 16'hB001});
    rx_beats.push_back({4'h3, 1'b0, 1'b1, 16'hB002});
    rx_beats.push_back({4'h9, 1'b1, 1'b0, 16'hB003});
    rx_beats.push_back({4'h1, 1'b0, 1'b1, 16'hB004});
    rx_beats.push_back({4'h3, 1'b1, 1'b1, 16'hB005});
    rx_exp.push_back({4'b0010, 1'b1, 1'b0, 16'hB000});
    rx_exp.push_back({4'b0010, 1'b0, 1'b0, 16'hB001});
    rx_exp.push_back({4'b0010, 1'b0, 1'b1, 16'hB002});
    rx_exp.push_back({4'b1000, 1'b1, 1'b1, 16'hB005});
    run_rx(20);
    check_eq("rx_drop_count", 32'(rr_drop), 32'd1);

    // Rx FIFO fill with ch0 stalled.
    ch_rx_ready = 4'h0;
    rx_beats.delete();
    drive_rx(0);
    do_reset(2);
    for (int i = 0; i < 6; i++) rx_beats.push_back({4'h0, i == 0, i == 5, 16'(16'hC000 + i)});
    idx = 0; nacc = 0; first_acc = -1; first_vld = -1;
    drive_rx(0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (first_vld < 0 && rr_ch_rx_valid[0]) first_vld = cyc;
      acc = rx_valid && rr_rx_ready;
      if (acc) begin
        nacc++;
        if (first_acc < 0) first_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      drive_rx(idx);
    end
    check_eq("rx_fill_accepts", 32'(nacc), 32'd4);
    check_eq("rx_latency", 32'(first_vld - first_acc), 32'd1);
    @(negedge clk);
    check_eq("rx_ready_full", {31'b0, rr_rx_ready}, 32'd0);
    check_eq("rx_head_valid", 32'(rr_ch_rx_valid), 32'd1);
    check_eq("rx_head_data0", 32'(rr_rx_data), 32'h0000C000);
    @(posedge clk);
    #1;
    ch_rx_ready = 4'b0001;
    @(negedge clk);
    check_eq("rx_ready_on_pop", {31'b0, rr_rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    idx++;
    drive_rx(idx);
    ch_rx_ready = 4'b0000;
    @(negedge clk);
    check_eq("rx_ready_still_full", {31'b0, rr_rx_ready}, 32'd0);
    check_eq("rx_head_data1", 32'(rr_rx_data), 32'h0000C001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
